// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, framing constants, parity helper.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      DONE
   } rx_state_t;

   localparam int unsigned STOP_BITS = 1;
   localparam int unsigned MIN_K     = 4;

   // Parity bit a transmitter appends to d: even parity when odd = 0, odd parity when odd = 1.
   function automatic logic parity_bit(input logic [7:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Loadable bit-period down-counter; tick pulses for one cycle when a loaded count expires.
module rx_bit_timer #(
   parameter int unsigned KW = 19
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_half,
   input  logic          load_full,
   input  logic [KW-1:0] baud_k,
   output logic          tick
);

   logic [KW-1:0] cnt;
   logic          run;

   // Half-period load lands the start recheck half a bit in; full load is one bit minus the reload cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         run <= 1'b0;
      end else if (load_half) begin
         cnt <= baud_k >> 1;
         run <= 1'b1;
      end else if (load_full) begin
         cnt <= baud_k - KW'(1);
         run <= 1'b1;
      end else if (run) begin
         if (cnt == '0) run <= 1'b0;
         else           cnt <= cnt - KW'(1);
      end
   end

   assign tick = run && (cnt == '0);

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizer, start detect, mid-bit sampling, frame assembly and status.
module uart_rx_engine
   import uart_pkg::*;
#(
   parameter int unsigned KW = 19
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rx,
   input  logic [KW-1:0] baud_k,
   input  logic          eight,
   input  logic          pen,
   input  logic          ohel,
   input  logic          clear,
   output logic [7:0]    data,
   output logic          rx_rdy,
   output logic          perr,
   output logic          ferr,
   output logic          ovf
);

   logic       s1, rxs;
   rx_state_t  state;
   logic [3:0] bitcnt;
   logic [9:0] sr;
   logic       tick, load_half, load_full;
   logic [3:0] nbits;
   logic       last;
   logic [9:0] frame;
   logic [7:0] dbyte;
   logic       pbit;

   // Two-flop synchronizer, idles high so reset does not look like a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1  <= 1'b1;
         rxs <= 1'b1;
      end else begin
         s1  <= rx;
         rxs <= s1;
      end
   end

   assign nbits = 4'd7 + {3'b000, eight} + {3'b000, pen} + 4'(STOP_BITS);
   // >= rather than == so a mid-frame shrink of the frame length still terminates.
   assign last  = (bitcnt + 4'd1) >= nbits;

   // Samples enter at bit 9, so the n-bit frame sits in the top n bits until shifted down.
   always_comb begin
      frame = sr >> (4'd10 - nbits);
      dbyte = eight ? frame[7:0] : {1'b0, frame[6:0]};
      pbit  = eight ? frame[8] : frame[7];
   end

   // Timer reloads: half period on start detect, full period after the recheck and each non-final sample.
   always_comb begin
      load_half = (state == IDLE) && !rxs;
      load_full = tick && (((state == START) && !rxs) || ((state == DATA) && !last));
   end

   rx_bit_timer #(.KW(KW)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .load_half (load_half),
      .load_full (load_full),
      .baud_k    (baud_k),
      .tick      (tick)
   );

   // Receive FSM, shift register and host-visible status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         bitcnt <= '0;
         sr     <= '0;
         data   <= '0;
         rx_rdy <= 1'b0;
         perr   <= 1'b0;
         ferr   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bitcnt <= '0;
               if (!rxs) state <= START;
            end
            START: begin
               if (tick) state <= rxs ? IDLE : DATA;
            end
            DATA: begin
               if (tick) begin
                  sr     <= {rxs, sr[9:1]};
                  bitcnt <= bitcnt + 4'd1;
                  if (last) state <= DONE;
               end
            end
            DONE: begin
               data  <= dbyte;
               perr  <= pen && (parity_bit(dbyte, ohel) != pbit);
               ferr  <= ~sr[9];
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (state == DONE) begin
            rx_rdy <= 1'b1;
            ovf    <= rx_rdy && !clear;
         end else if (clear) begin
            rx_rdy <= 1'b0;
            ovf    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine with a frame-level reference model and per-cycle compare.
module tb_uart_rx_engine;

   localparam int unsigned KW = 19;

   logic          clk    = 1'b0;
   logic          reset  = 1'b1;
   logic          rx     = 1'b1;
   logic [KW-1:0] baud_k = KW'(16);
   logic          eight  = 1'b1;
   logic          pen    = 1'b0;
   logic          ohel   = 1'b0;
   logic          clear  = 1'b0;
   logic [7:0]    data;
   logic          rx_rdy, perr, ferr, ovf;

   uart_rx_engine #(.KW(KW)) dut (
      .clk    (clk),
      .reset  (reset),
      .rx     (rx),
      .baud_k (baud_k),
      .eight  (eight),
      .pen    (pen),
      .ohel   (ohel),
      .clear  (clear),
      .data   (data),
      .rx_rdy (rx_rdy),
      .perr   (perr),
      .ferr   (ferr),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   // Edge counter: after the Nth rising edge, cyc == N.
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned at;
      logic [7:0]  d;
      logic        pe;
      logic        fe;
   } exp_t;

   exp_t       q[$];
   logic [7:0] m_data = 8'h00;
   logic       m_rdy  = 1'b0;
   logic       m_perr = 1'b0;
   logic       m_ferr = 1'b0;
   logic       m_ovf  = 1'b0;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // Reference model: a queued character lands on the edge its frame timing predicts.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_data = 8'h00; m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
         q.delete();
      end else if (q.size() > 0 && q[0].at == cyc + 1) begin
         m_ovf  = m_rdy & ~clear;
         m_rdy  = 1'b1;
         m_data = q[0].d;
         m_perr = q[0].pe;
         m_ferr = q[0].fe;
         void'(q.pop_front());
      end else if (clear) begin
         m_rdy = 1'b0;
         m_ovf = 1'b0;
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      chk("data",   data,           m_data);
      chk("rx_rdy", {7'b0, rx_rdy}, {7'b0, m_rdy});
      chk("perr",   {7'b0, perr},   {7'b0, m_perr});
      chk("ferr",   {7'b0, ferr},   {7'b0, m_ferr});
      chk("ovf",    {7'b0, ovf},    {7'b0, m_ovf});
   end

   // Drives one frame, each bit held baud_k clocks; optional clear in the DONE cycle or reset abort.
   task automatic send_frame(input logic [7:0] d, input logic p, input logic stopb,
                             input bit clr_done, input int abort_at);
      int unsigned k, h, nd, n, idx, pp;
      logic        bits[11];
      logic [7:0]  ed;
      exp_t        e;
      k  = baud_k;
      h  = k / 2;
      nd = eight ? 8 : 7;
      n  = nd + (pen ? 1 : 0) + 1;
      bits[0] = 1'b0;
      for (int unsigned i = 0; i < nd; i++) bits[1+i] = d[i];
      idx = 1 + nd;
      if (pen) begin
         bits[idx] = p;
         idx++;
      end
      bits[idx] = stopb;
      ed = eight ? d : {1'b0, d[6:0]};
      @(posedge clk); #1;
      pp   = cyc;
      e.at = pp + 5 + h + k * n;
      e.d  = ed;
      e.pe = pen & (((^ed) ^ p) != ohel);
      e.fe = ~stopb;
      q.push_back(e);
      for (int unsigned j = 0; j < k * (n + 1); j++) begin
         if (j > 0) begin
            @(posedge clk); #1;
         end
         if (abort_at > 0 && j == abort_at) begin
            rx    = 1'b1;
            clear = 1'b0;
            reset = 1'b1;
            return;
         end
         rx    = bits[j / k];
         clear = clr_done && (j == 4 + h + k * n);
      end
      @(posedge clk); #1;
      rx    = 1'b1;
      clear = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
   endtask

   task automatic cfg(input int unsigned k, input logic e8, input logic pe, input logic od);
      baud_k = KW'(k);
      eight  = e8;
      pen    = pe;
      ohel   = od;
   endtask

   initial begin
      idle(3);
      reset = 1'b0;
      chk("reset_data", data, 8'h00);
      chk("reset_rdy",  {7'b0, rx_rdy}, 8'h00);

      // 8N1 basic frame
      cfg(16, 1, 0, 0);
      send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
      idle(42);
      chk("t1_data", data, 8'hA5);
      chk("t1_rdy",  {7'b0, rx_rdy}, 8'h01);
      chk("t1_err",  {5'b0, perr, ferr, ovf}, 8'h00);
      pulse_clear();

      // 7E1 correct and wrong parity, 8O1 correct parity
      cfg(16, 0, 1, 0);
      send_frame(8'h41, 1'b0, 1'b1, 0, 0);
      idle(42);
      chk("t2a_data", data, 8'h41);
      chk("t2a_perr", {7'b0, perr}, 8'h00);
      pulse_clear();
      send_frame(8'h41, 1'b1, 1'b1, 0, 0);
      idle(42);
      chk("t2b_perr", {7'b0, perr}, 8'h01);
      pulse_clear();
      cfg(16, 1, 1, 1);
      send_frame(8'hFF, 1'b1, 1'b1, 0, 0);
      idle(42);
      chk("t2c_data", data, 8'hFF);
      chk("t2c_perr", {7'b0, perr}, 8'h00);
      pulse_clear();

      // short low glitch on idle line
      cfg(16, 1, 0, 0);
      @(posedge clk); #1 rx = 1'b0;
      idle(3);
      rx = 1'b1;
      idle(30);
      chk("t3_rdy", {7'b0, rx_rdy}, 8'h00);

      // framing error then recovery
      send_frame(8'h3C, 1'b0, 1'b0, 0, 0);
      idle(42);
      chk("t4a_data", data, 8'h3C);
      chk("t4a_ferr", {7'b0, ferr}, 8'h01);
      pulse_clear();
      send_frame(8'h5A, 1'b0, 1'b1, 0, 0);
      idle(42);
      chk("t4b_data", data, 8'h5A);
      chk("t4b_ferr", {7'b0, ferr}, 8'h00);

      // overrun, then clear coinciding with DONE
      pulse_clear();
      send_frame(8'h11, 1'b0, 1'b1, 0, 0);
      idle(42);
      send_frame(8'h22, 1'b0, 1'b1, 0, 0);
      idle(42);
      chk("t5a_data", data, 8'h22);
      chk("t5a_ovf",  {7'b0, ovf}, 8'h01);
      send_frame(8'h33, 1'b0, 1'b1, 1, 0);
      idle(42);
      chk("t5b_data", data, 8'h33);
      chk("t5b_rdy",  {7'b0, rx_rdy}, 8'h01);
      chk("t5b_ovf",  {7'b0, ovf}, 8'h00);

      // reset mid-data, then a frame at the odd minimum-ish rate
      send_frame(8'h96, 1'b0, 1'b1, 0, 16 * 3);
      #1;
      chk("t6_rst_data", data, 8'h00);
      chk("t6_rst_flags", {3'b0, rx_rdy, perr, ferr, ovf, 1'b0}, 8'h00);
      idle(2);
      reset = 1'b0;
      idle(2);
      cfg(5, 1, 0, 0);
      send_frame(8'h96, 1'b0, 1'b1, 0, 0);
      idle(20);
      chk("t6_data", data, 8'h96);
      chk("t6_rdy",  {7'b0, rx_rdy}, 8'h01);
      chk("t6_err",  {5'b0, perr, ferr, ovf}, 8'h00);

      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
